// File: rtl/midi_event_parser.sv
// rtl/midi_event_parser.sv - MIDI channel-voice byte parser feeding a small event FIFO
module midi_event_parser #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] CHAN_MASK  = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [1:0]                    evt_type,
    output logic [3:0]                    evt_chan,
    output logic [6:0]                    evt_data1,
    output logic [6:0]                    evt_data2,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    state_t        state;
    logic [7:0]    rs;
    logic [6:0]    d1;

    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [19:0]   head;

    logic          is_data;
    logic          complete;
    logic          type_ok;
    logic [1:0]    new_type;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          full;

    always_comb begin
        is_data  = byte_valid && !byte_in[7];
        complete = is_data && (state == WAIT_D2);
        type_ok  = 1'b1;
        new_type = 2'b00;
        case (rs[7:4])
            4'h8:    new_type = 2'b00;
            4'h9:    new_type = (byte_in[6:0] == 7'd0) ? 2'b00 : 2'b01;
            4'hB:    new_type = 2'b10;
            4'hE:    new_type = 2'b11;
            default: type_ok  = 1'b0;
        endcase
        push_req = complete && type_ok && CHAN_MASK[rs[3:0]];
        full     = (evt_count == DEPTH);
        do_pop   = evt_valid && evt_ready;
        do_push  = push_req && (!full || do_pop);
    end

    // Realtime bytes (0xF8-0xFF) fall through every branch and leave the parser untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rs    <= 8'd0;
            d1    <= 7'd0;
        end else if (byte_valid) begin
            if (byte_in[7]) begin
                if (byte_in[7:4] != 4'hF) begin
                    rs    <= byte_in;
                    state <= WAIT_D1;
                end else if (!byte_in[3]) begin
                    rs    <= 8'd0;
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: ;
                    WAIT_D1: begin
                        if (rs[7:4] != 4'hC && rs[7:4] != 4'hD) begin
                            d1    <= byte_in[6:0];
                            state <= WAIT_D2;
                        end
                    end
                    WAIT_D2: state <= WAIT_D1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: evt_count <= evt_count;
            endcase
            if (push_req && full && !do_pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= {new_type, rs[3:0], d1, byte_in[6:0]};
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (evt_count != '0);
    assign evt_type  = reset ? 2'd0 : head[19:18];
    assign evt_chan  = reset ? 4'd0 : head[17:14];
    assign evt_data1 = reset ? 7'd0 : head[13:7];
    assign evt_data2 = reset ? 7'd0 : head[6:0];

endmodule

// File: doc/midi_event_parser.md
MIDI_EVENT_PARSER -- requirements
Module: midi_event_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event FIFO depth; power of two, 2..16.
REQ-002 Parameter CHAN_MASK, default 16'hFFFF: bit n set means MIDI channel n events are emitted.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port byte_in  input  8: received MIDI byte, qualified by byte_valid.
REQ-006 Port byte_valid  input  1: one-cycle strobe, byte_in valid; no backpressure to the receiver.
REQ-007 Port evt_valid  output  1: FIFO non-empty; head event presented.
REQ-008 Port evt_ready  input  1: consumer accepts the head event when evt_valid is also high.
REQ-009 Port evt_type  output  2: 00 note-off, 01 note-on, 10 control change, 11 pitch bend.
REQ-010 Port evt_chan  output  4: channel nibble of the status byte.
REQ-011 Port evt_data1  output  7: note, controller number, or pitch-bend LSB.
REQ-012 Port evt_data2  output  7: velocity, controller value, or pitch-bend MSB.
REQ-013 Port evt_count  output  $clog2(FIFO_DEPTH)+1: number of events held in the FIFO.
REQ-014 Port overflow  output  1: sticky flag, set when an event is dropped because the FIFO is full.

Function
REQ-015 The parser SHALL be an FSM with states IDLE (no running status), WAIT_D1 and WAIT_D2, plus a running-status register rs[7:0].
REQ-016 A byte 0x80-0xEF SHALL load rs, enter WAIT_D1 and discard any partial message.
REQ-017 A byte 0xF0-0xF7 SHALL clear running status and enter IDLE.
REQ-018 A byte 0xF8-0xFF (realtime) SHALL be ignored with no change to FSM, rs or any partial data.
REQ-019 A data byte (bit7=0) in IDLE SHALL be discarded.
REQ-020 In WAIT_D1, for rs high nibble 8, 9, A, B or E, a data byte SHALL be latched as d1 and the FSM SHALL enter WAIT_D2.
REQ-021 In WAIT_D1, for rs high nibble C or D, a data byte SHALL complete a one-byte message that is discarded; the FSM SHALL stay in WAIT_D1.
REQ-022 In WAIT_D2, a data byte SHALL complete the message and return the FSM to WAIT_D1 (running status retained).
REQ-023 On completion, nibble 8 SHALL map to type 00, 9 to 01, B to 10 and E to 11; nibble A (aftertouch) SHALL be discarded.
REQ-024 Note-on with velocity 0 SHALL be emitted as type 00 with data2=0.
REQ-025 A completed message SHALL be pushed only if CHAN_MASK[rs[3:0]] is set; otherwise it is discarded silently.
REQ-026 Latency: a push occurs at the edge that samples the final data byte, so evt_valid is high on the next cycle when the FIFO was empty.
REQ-027 A pop SHALL occur when evt_valid && evt_ready; the head SHALL advance on the same edge.
REQ-028 Outputs SHALL be driven directly from the FIFO head; evt_* values SHALL be stable while evt_valid && !evt_ready.
REQ-029 Push when full without a simultaneous pop SHALL drop the new event, set overflow, and leave the FIFO contents unchanged.
REQ-030 Simultaneous push and pop when full SHALL both succeed; evt_count stays FIFO_DEPTH and overflow is not set.
REQ-031 Simultaneous push and pop when empty SHALL not pop; the push succeeds and evt_count becomes 1.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 overflow SHALL remain set until reset.

Reset
REQ-034 With reset high at a clock edge, the block SHALL enter IDLE, set rs=0, clear the FIFO pointers and evt_count, and set evt_valid=0 and overflow=0.
REQ-035 While reset is high, evt_type, evt_chan, evt_data1 and evt_data2 SHALL read 0, and byte_valid SHALL be ignored.
REQ-036 Reset asserted mid-message SHALL discard the partial message; a data byte after reset SHALL be dropped until a new status byte arrives.

Verification
REQ-037 Stimulus 0x93,0x3C,0x64 with evt_ready=1 -> one event: type 01, chan 3, data1 0x3C, data2 0x64, valid exactly one cycle after 0x64.
REQ-038 Stimulus 0x90,0x40,0x7F,0x40,0x00 (running status) -> note-on 0x40/0x7F, then note-off chan 0, data1 0x40, data2 0.
REQ-039 Stimulus 0xB1,0x07,0xF8,0x50 -> CC event chan 1, data1 0x07, data2 0x50 (realtime 0xF8 transparent).
REQ-040 Stimulus 0xC2,0x05,0xE0,0x00,0x40 -> no event for program change; pitch bend chan 0, data1 0x00, data2 0x40.
REQ-041 With CHAN_MASK=16'h0001, evt_ready=0 and FIFO_DEPTH=4: channel-5 note-on -> no event; five channel-0 note-ons -> evt_count=4, overflow=1, head is the first note.
REQ-042 Stimulus 0x90,0x3C, then reset, then 0x64 -> no event; evt_valid=0 and overflow=0.
